// File: rtl/waveform_readout_ctrl.sv
// Waveform readout controller: arms on a threshold crossing or forced trigger, waits out the
// capture-buffer fill, then streams a header byte and the record (MSB byte first) to the UART.
module waveform_readout_ctrl #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned DATA_W   = 14,
  parameter logic [7:0]  HDR_BYTE = 8'hA5,
  parameter int unsigned HOLDOFF  = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        signal,
  input  logic [DATA_W-1:0]        threshold,
  input  logic                     arm,
  input  logic                     continuous,
  input  logic                     force_trig,
  output logic                     trig_out,
  output logic [$clog2(DEPTH)-1:0] rd_index,
  input  logic [DATA_W-1:0]        rd_sample,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned CNT_MAX = (HOLDOFF > DEPTH) ? HOLDOFF : DEPTH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_SEND_HDR,
    S_SEND_HI,
    S_SEND_LO,
    S_HOLDOFF
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [IDX_W-1:0]   idx_nx;
  logic [DATA_W-1:0]  prev;
  logic               done_nx;
  logic               crossing;

  assign crossing = (prev < threshold) && (signal >= threshold);

  // prev tracks the live sample whenever a trigger may follow, so ARMED always
  // compares against the sample from the cycle before.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rd_index   <= '0;
      prev       <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      rd_index   <= idx_nx;
      frame_done <= done_nx;
      if (state == S_IDLE || state == S_ARMED || state == S_HOLDOFF)
        prev <= signal;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = rd_index;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (arm) state_nx = S_ARMED;
      end
      S_ARMED: begin
        if (crossing || force_trig) begin
          state_nx = S_CAPTURE;
          cnt_nx   = '0;
        end
      end
      S_CAPTURE: begin
        if (cnt == CNT_W'(DEPTH)) begin
          state_nx = S_SEND_HDR;
          cnt_nx   = '0;
          idx_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_SEND_HDR: if (tx_ready) state_nx = S_SEND_HI;
      S_SEND_HI:  if (tx_ready) state_nx = S_SEND_LO;
      S_SEND_LO: begin
        if (tx_ready) begin
          if (rd_index == IDX_W'(DEPTH - 1)) begin
            idx_nx   = '0;
            done_nx  = 1'b1;
            cnt_nx   = '0;
            state_nx = continuous ? S_HOLDOFF : S_IDLE;
          end else begin
            idx_nx   = rd_index + IDX_W'(1);
            state_nx = S_SEND_HI;
          end
        end
      end
      S_HOLDOFF: begin
        if (!continuous) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(HOLDOFF - 1)) begin
          state_nx = S_ARMED;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs decode straight from the state register; tx_data follows the
  // combinational buffer read, so it holds while rd_index holds.
  always_comb begin
    trig_out = (state == S_CAPTURE) && (cnt == '0);
    busy     = (state != S_IDLE);
    tx_valid = (state == S_SEND_HDR) || (state == S_SEND_HI) || (state == S_SEND_LO);
    tx_data  = '0;
    case (state)
      S_SEND_HDR: tx_data = HDR_BYTE;
      S_SEND_HI:  tx_data = 8'(rd_sample >> 8);
      S_SEND_LO:  tx_data = rd_sample[7:0];
      default:    tx_data = '0;
    endcase
  end

endmodule

// File: doc/waveform_readout_ctrl.md
Name: waveform_readout_ctrl

Overview:
- Sequences the 64-sample ADC waveform capture buffer and streams the captured record to the UART transmitter.
- Arms on request and detects a rising threshold crossing on the live ADC sample, or accepts a forced trigger. It then issues a one-cycle trigger pulse to the capture buffer and waits out the fill.
- Reads the buffer back by index and sends a framed byte stream over a valid/ready byte interface.
- Sits between the ADC sample path, the capture buffer and the UART TX.

Parameters:
- DEPTH, 64, samples per record; must equal the capture buffer length (power of 2).
- DATA_W, 14, ADC sample width (9..16).
- HDR_BYTE, 8'hA5, frame header byte.
- HOLDOFF, 1024, idle cycles enforced after a frame before re-arming in continuous mode.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- signal  in  DATA_W  live ADC sample, unsigned.
- threshold  in  DATA_W  trigger level, unsigned.
- arm  in  1  level; arms acquisition when in IDLE.
- continuous  in  1  1 = re-arm automatically after HOLDOFF; 0 = single shot.
- force_trig  in  1  trigger immediately when ARMED.
- trig_out  out  1  one-cycle trigger pulse to the capture buffer.
- rd_index  out  log2(DEPTH)  buffer read index.
- rd_sample  in  DATA_W  buffer word at rd_index (combinational read).
- tx_data  out  8  byte to UART.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART accepts byte.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse after last byte accepted.

Behaviour:
- Reset (async, reset_n=0): state IDLE; trig_out=0, rd_index=0, tx_data=0, tx_valid=0, busy=0, frame_done=0; prev-sample register=0; all counters=0. Reset mid-frame abandons the frame with no further bytes.
- Byte transfer occurs on a rising clk edge with tx_valid=1 and tx_ready=1. While tx_valid=1, tx_data and rd_index are held stable until accepted.
- IDLE: arm=1 -> ARMED next cycle. Load prev = signal.
- ARMED:
  - Each cycle, prev <= signal.
  - Crossing = (prev < threshold) && (signal >= threshold). A level already above threshold does not trigger.
  - On crossing or force_trig -> trig_out=1 for exactly the next cycle; enter CAPTURE.
  - Neither arm nor continuous affects the wait.
- CAPTURE: a counter runs DEPTH+1 cycles, starting the cycle trig_out is high. It covers the buffer fill of DEPTH cycles plus 1 settle cycle. Then -> SEND_HDR with rd_index=0. Triggers are ignored.
- SEND_HDR: tx_valid=1, tx_data=HDR_BYTE; on accept -> SEND_HI.
- SEND_HI: tx_data = upper byte = {zero-pad, rd_sample[DATA_W-1:8]}; on accept -> SEND_LO.
- SEND_LO: tx_data = rd_sample[7:0].
  - On accept with rd_index != DEPTH-1: rd_index++ and go to SEND_HI.
  - On accept with rd_index == DEPTH-1: rd_index=0, frame_done=1 for one cycle, tx_valid=0; go to HOLDOFF if continuous=1, else IDLE.
- tx_valid deasserts only in the cycle after the final accept; back-to-back bytes sustain one byte per cycle when tx_ready is held high.
- Frame length is 1 + 2*DEPTH bytes (129 at default), MSB byte first per sample.
- HOLDOFF: count HOLDOFF cycles, then -> ARMED; prev reloaded from signal on entry to ARMED. Clearing continuous during HOLDOFF -> IDLE next cycle.
- busy = (state != IDLE), registered with the state.
- Simultaneous arm and force_trig in IDLE: arm only; force_trig is evaluated from ARMED onward.
- tx_ready held low indefinitely: block stalls in the current SEND state, no timeout.
- continuous is sampled only at the final accept and during HOLDOFF.

Test Plan:
- Arm, single shot, threshold=8000, signal ramps 7990->8010 in steps of 5 -> trig_out pulses once, the cycle after the first sample >=8000 with prev <8000. CAPTURE lasts 65 cycles.
- Signal held at 9000 above threshold=8000 while ARMED -> no trigger. force_trig=1 -> trig_out pulse next cycle.
- rd_sample = 14'h3A5C at index 0, index i elsewhere, tx_ready=1 -> bytes A5, 3A, 5C, 00, 01, ..., 00, 3F. Total 129 bytes, one per cycle; frame_done one cycle after the last; returns to IDLE.
- tx_ready toggled pseudo-randomly (~30% high) -> identical 129-byte stream. tx_data and rd_index stable while tx_valid=1 and tx_ready=0.
- continuous=1, HOLDOFF=16 -> second frame's ARMED entry exactly 16 cycles after the first frame_done. Clear continuous during HOLDOFF -> IDLE, busy=0.
- reset_n pulsed low after byte 40 -> all outputs zero immediately (asynchronous), state IDLE. A new arm produces a complete 129-byte frame.
